// File: rtl/cpu_control_unit.sv
// Purpose: LEGv8-subset main + ALU decoder in ID; maps opcode[31:21] to datapath controls and keeps a sticky illegal-opcode flag.
// Latency: control outputs are purely combinational (zero cycles); illegal updates on the rising clk edge.
// Backpressure: none, no handshake; optional AND/EOR rows are enabled by defining CPU_CONTROL_LOGIC_EN.
module cpu_control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] opcode,
  input  logic        sign,
  output logic        Reg2Loc,
  output logic        ALU_Src,
  output logic        Imm,
  output logic        ALU_SH,
  output logic        shiftDirn,
  output logic        ALU_on,
  output logic [2:0]  ALU_cntrl,
  output logic        set_flags,
  output logic        memRead,
  output logic        memWrite,
  output logic        memToReg,
  output logic        RegWrite,
  output logic        branch,
  output logic        uncondBr,
  output logic        branchReg,
  output logic        branchLink,
  output logic [1:0]  fwdEn,
  output logic        illegal
);

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
`ifdef CPU_CONTROL_LOGIC_EN
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_XOR    = 3'b110;
`endif

  localparam logic [1:0] FWD_I = 2'b10;
  localparam logic [1:0] FWD_R = 2'b11;

  typedef struct packed {
    logic       reg2loc;
    logic       alu_src;
    logic       imm;
    logic       alu_sh;
    logic       shift_dirn;
    logic       alu_on;
    logic [2:0] alu_cntrl;
    logic       set_flags;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       branch;
    logic       uncond_br;
    logic       branch_reg;
    logic       branch_link;
    logic [1:0] fwd_en;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctl;
  logic  hit;

  // loads/stores add or subtract the 9-bit offset depending on its sign
  logic [2:0] addr_op;
  assign addr_op = sign ? ALU_SUB : ALU_ADD;

  // opcode-prefix decode; hit drops for anything not in the instruction table
  always_comb begin
    dec = '0;
    hit = 1'b1;
    casez (opcode)
      11'b10101011000: begin // ADDS
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.set_flags = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_ADD;
        dec.fwd_en    = FWD_R;
      end
      11'b11101011000: begin // SUBS
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.set_flags = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_SUB;
        dec.fwd_en    = FWD_R;
      end
      11'b1001000100?: begin // ADDI
        dec.alu_src   = 1'b1;
        dec.imm       = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_ADD;
        dec.fwd_en    = FWD_I;
      end
      11'b11111000010: begin // LDUR
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_on     = 1'b1;
        dec.alu_cntrl  = addr_op;
      end
      11'b11111000000: begin // STUR
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = addr_op;
      end
      11'b11010011011: begin // LSL
        dec.alu_sh    = 1'b1;
        dec.reg_write = 1'b1;
      end
      11'b11010011010: begin // LSR
        dec.alu_sh     = 1'b1;
        dec.reg_write  = 1'b1;
        dec.shift_dirn = 1'b1;
      end
      11'b000101?????: begin // B
        dec.branch    = 1'b1;
        dec.uncond_br = 1'b1;
      end
      11'b100101?????: begin // BL: link register written with PC+4 through a pass-B ALU op
        dec.branch      = 1'b1;
        dec.uncond_br   = 1'b1;
        dec.branch_link = 1'b1;
        dec.reg_write   = 1'b1;
        dec.alu_on      = 1'b1;
        dec.alu_cntrl   = ALU_PASS_B;
      end
      11'b01010100???: begin // B.cond
        dec.branch = 1'b1;
      end
      11'b10110100???: begin // CBZ: tested register passes through the ALU for the zero check
        dec.branch    = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_PASS_B;
      end
      11'b11010110000: begin // BR
        dec.branch     = 1'b1;
        dec.branch_reg = 1'b1;
      end
`ifdef CPU_CONTROL_LOGIC_EN
      11'b10001010000: begin // AND
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_AND;
        dec.fwd_en    = FWD_R;
      end
      11'b11001010000: begin // EOR
        dec.reg2loc   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_on    = 1'b1;
        dec.alu_cntrl = ALU_XOR;
        dec.fwd_en    = FWD_R;
      end
`endif
      default: hit = 1'b0;
    endcase
  end

  // reset squashes every control bit so nothing leaks into ID/EX during reset
  always_comb begin
    ctl = rst ? ctrl_t'('0) : dec;
  end

  assign Reg2Loc    = ctl.reg2loc;
  assign ALU_Src    = ctl.alu_src;
  assign Imm        = ctl.imm;
  assign ALU_SH     = ctl.alu_sh;
  assign shiftDirn  = ctl.shift_dirn;
  assign ALU_on     = ctl.alu_on;
  assign ALU_cntrl  = ctl.alu_cntrl;
  assign set_flags  = ctl.set_flags;
  assign memRead    = ctl.mem_read;
  assign memWrite   = ctl.mem_write;
  assign memToReg   = ctl.mem_to_reg;
  assign RegWrite   = ctl.reg_write;
  assign branch     = ctl.branch;
  assign uncondBr   = ctl.uncond_br;
  assign branchReg  = ctl.branch_reg;
  assign branchLink = ctl.branch_link;
  assign fwdEn      = ctl.fwd_en;

  // sticky illegal-opcode status: only reset clears it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal <= 1'b0;
    end else if (!hit) begin
      illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_control_unit.sv
// Purpose: randomized + directed check of cpu_control_unit against a rule-level decode model.
// Latency: outputs compared every falling edge; illegal model tracks rising edges.
// Backpressure: none; stimulus is applied 1 time unit after each rising edge.
module tb_cpu_control_unit;

  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_ADDI = 11'b10010001000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_B    = 11'b00010100000;
  localparam logic [10:0] OP_BL   = 11'b10010100000;
  localparam logic [10:0] OP_BC   = 11'b01010100000;
  localparam logic [10:0] OP_CBZ  = 11'b10110100000;
  localparam logic [10:0] OP_BR   = 11'b11010110000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_EOR  = 11'b11001010000;
  localparam logic [10:0] OP_ALL1 = 11'b11111111111;

`ifdef CPU_CONTROL_LOGIC_EN
  localparam bit LOGIC_EN = 1'b1;
`else
  localparam bit LOGIC_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [10:0] opcode;
  logic        sign;
  logic        Reg2Loc, ALU_Src, Imm, ALU_SH, shiftDirn, ALU_on;
  logic [2:0]  ALU_cntrl;
  logic        set_flags, memRead, memWrite, memToReg, RegWrite;
  logic        branch, uncondBr, branchReg, branchLink;
  logic [1:0]  fwdEn;
  logic        illegal;

  cpu_control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .sign(sign),
    .Reg2Loc(Reg2Loc), .ALU_Src(ALU_Src), .Imm(Imm), .ALU_SH(ALU_SH),
    .shiftDirn(shiftDirn), .ALU_on(ALU_on), .ALU_cntrl(ALU_cntrl),
    .set_flags(set_flags), .memRead(memRead), .memWrite(memWrite),
    .memToReg(memToReg), .RegWrite(RegWrite), .branch(branch),
    .uncondBr(uncondBr), .branchReg(branchReg), .branchLink(branchLink),
    .fwdEn(fwdEn), .illegal(illegal)
  );

  logic [19:0] dut_ctl;
  assign dut_ctl = {Reg2Loc, ALU_Src, Imm, ALU_SH, shiftDirn, ALU_on, ALU_cntrl,
                    set_flags, memRead, memWrite, memToReg, RegWrite,
                    branch, uncondBr, branchReg, branchLink, fwdEn};

  int n_vec = 0;
  int n_err = 0;
  bit run   = 1'b0;
  bit m_ill = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Rule-level model: returns {legal, control vector in dut_ctl order}.
  function automatic logic [20:0] model(input logic [10:0] op, input logic sg);
    logic r2l, src, imm, sh, dirn, alu, sf, mr, mw, m2r, rw, br, ub, brr, bl, hit;
    logic [2:0] c;
    logic [1:0] fw;
    {r2l, src, imm, sh, dirn, alu, c, sf, mr, mw, m2r, rw, br, ub, brr, bl, fw} = 20'd0;
    hit = 1'b1;
    if (op == OP_ADDS || op == OP_SUBS) begin
      r2l = 1; rw = 1; sf = 1; alu = 1; fw = 2'b11;
      c = (op == OP_SUBS) ? 3'd3 : 3'd2;
    end else if (op[10:1] == 10'b1001000100) begin
      src = 1; imm = 1; rw = 1; alu = 1; c = 3'd2; fw = 2'b10;
    end else if (op == OP_LDUR || op == OP_STUR) begin
      src = 1; alu = 1; c = sg ? 3'd3 : 3'd2;
      if (op == OP_LDUR) begin mr = 1; m2r = 1; rw = 1; end
      else mw = 1;
    end else if (op == OP_LSL || op == OP_LSR) begin
      sh = 1; rw = 1; dirn = (op == OP_LSR);
    end else if (op[10:5] == 6'b000101) begin
      br = 1; ub = 1;
    end else if (op[10:5] == 6'b100101) begin
      br = 1; ub = 1; bl = 1; rw = 1; alu = 1;
    end else if (op[10:3] == 8'b01010100) begin
      br = 1;
    end else if (op[10:3] == 8'b10110100) begin
      br = 1; alu = 1;
    end else if (op == OP_BR) begin
      br = 1; brr = 1;
    end else if (LOGIC_EN && (op == OP_AND || op == OP_EOR)) begin
      r2l = 1; rw = 1; alu = 1; fw = 2'b11;
      c = (op == OP_AND) ? 3'd4 : 3'd6;
    end else begin
      hit = 1'b0;
    end
    return {hit, r2l, src, imm, sh, dirn, alu, c, sf, mr, mw, m2r, rw, br, ub, brr, bl, fw};
  endfunction

  // sticky illegal model
  always @(posedge clk or posedge rst) begin
    logic [20:0] m;
    if (rst) begin
      m_ill = 1'b0;
    end else begin
      m = model(opcode, sign);
      if (!m[20]) m_ill = 1'b1;
    end
  end

  // per-cycle compare of all outputs against the model
  always @(negedge clk) begin
    logic [20:0] m;
    logic [19:0] e;
    if (run) begin
      m = model(opcode, sign);
      e = rst ? 20'd0 : m[19:0];
      n_vec++;
      if (dut_ctl !== e || illegal !== m_ill) begin
        n_err++;
        $display("FAIL ctl_vec t=%0t op=%b sign=%b rst=%b got=%h ill=%b want=%h ill=%b",
                 $time, opcode, sign, rst, dut_ctl, illegal, e, m_ill);
      end
    end
  end

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic drive(input logic [10:0] op, input logic sg, input logic r);
    @(posedge clk);
    #1;
    opcode = op;
    sign   = sg;
    rst    = r;
    @(negedge clk);
  endtask

  function automatic logic [10:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 15))
      0:  return OP_ADDS;
      1:  return OP_SUBS;
      2:  return {10'b1001000100, r[0]};
      3:  return OP_LDUR;
      4:  return OP_STUR;
      5:  return OP_LSL;
      6:  return OP_LSR;
      7:  return {6'b000101, r[4:0]};
      8:  return {6'b100101, r[4:0]};
      9:  return {8'b01010100, r[2:0]};
      10: return {8'b10110100, r[2:0]};
      11: return OP_BR;
      12: return OP_AND;
      13: return OP_EOR;
      14: return OP_ALL1;
      default: return r[10:0];
    endcase
  endfunction

  initial begin
    rst = 1'b0; opcode = 11'd0; sign = 1'b0;
    #1 rst = 1'b1;
    opcode = OP_ADDS;
    @(negedge clk);
    run = 1'b1;

    // reset forces everything low even with a valid opcode
    drive(OP_ADDS, 1'b0, 1'b1);
    check("rst_ctl", dut_ctl, 20'd0);
    check("rst_illegal", {19'd0, illegal}, 20'd0);

    // ADDS appears in the same cycle reset drops
    drive(OP_ADDS, 1'b0, 1'b0);
    check("adds_vec", dut_ctl, 20'b1_0_0_0_0_1_010_1_0_0_0_1_0_0_0_0_11);

    drive(OP_SUBS, 1'b0, 1'b0);
    check("subs_cntrl", {17'd0, ALU_cntrl}, 20'd3);
    check("subs_flags_fwd", {16'd0, set_flags, Reg2Loc, fwdEn}, 20'b1111);

    drive(OP_ADDI, 1'b0, 1'b0);
    check("addi_imm_src_fwd", {16'd0, Imm, ALU_Src, fwdEn}, 20'b1110);

    drive(OP_LDUR, 1'b0, 1'b0);
    check("ldur_pos", {17'd0, ALU_cntrl}, 20'd2);
    drive(OP_LDUR, 1'b1, 1'b0);
    check("ldur_neg", {17'd0, ALU_cntrl}, 20'd3);

    drive(OP_STUR, 1'b0, 1'b0);
    check("stur", {17'd0, memWrite, Reg2Loc, RegWrite}, 20'b100);

    drive(OP_B, 1'b0, 1'b0);
    check("b", {18'd0, branch, uncondBr}, 20'b11);
    drive(OP_BL, 1'b0, 1'b0);
    check("bl", {17'd0, branchLink, RegWrite, ALU_on}, 20'b111);
    drive(OP_BC, 1'b0, 1'b0);
    check("bcond", {18'd0, branch, uncondBr}, 20'b10);
    drive(OP_BR, 1'b0, 1'b0);
    check("br", {18'd0, branchReg, branch}, 20'b11);
    check("no_illegal_yet", {19'd0, illegal}, 20'd0);

    // all-ones must not alias a load/store
    drive(OP_ALL1, 1'b1, 1'b0);
    check("all1_ctl", dut_ctl, 20'd0);
    drive(OP_ADDS, 1'b0, 1'b0);
    check("all1_illegal", {19'd0, illegal}, 20'd1);
    drive(OP_LSR, 1'b0, 1'b0);
    check("illegal_sticky", {19'd0, illegal}, 20'd1);
    check("lsr", {18'd0, ALU_SH, shiftDirn}, 20'b11);

    drive(OP_ADDS, 1'b0, 1'b1);
    check("illegal_cleared", {19'd0, illegal}, 20'd0);

    drive(OP_AND, 1'b0, 1'b0);
    if (LOGIC_EN) check("and_vec", {16'd0, ALU_cntrl, RegWrite}, 20'b1001);
    else          check("and_nop", dut_ctl, 20'd0);
    drive(OP_ADDS, 1'b0, 1'b0);
    check("and_illegal", {19'd0, illegal}, {19'd0, !LOGIC_EN});

    // randomized phase; the compare process checks every cycle
    for (int i = 0; i < 3000; i++) begin
      drive(rand_op(), 1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0));
    end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
